rev_gate_sequencer: RTL and testbench

REV_GATE_SEQUENCER -- requirements
Module: rev_gate_sequencer

---
 rtl/rev_gate_sequencer.sv | 154 +++++++++++++++
 tb/tb_rev_gate_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rev_gate_sequencer.sv
// Reversible-gate sequencer: applies NOT/CNOT/FANOUT/TOFFOLI to a 5-bit register.
// Define REV_GATE_HIST_EN to enable the undo-history stack; otherwise undo always errors.
module rev_gate_sequencer #(
    parameter int HIST_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [4:0] load_data,
    input  logic       cmd_valid,
    input  logic [7:0] cmd,
    output logic       cmd_ready,
    input  logic       undo_req,
    output logic [4:0] state_out,
    output logic [4:0] hist_count,
    output logic       gate_done,
    output logic       err
);

    if (HIST_DEPTH < 2 || HIST_DEPTH > 16 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("HIST_DEPTH must be a power of 2 in 2..16");
    end

    function automatic logic gate_legal(input logic [7:0] g);
        logic [2:0] ctl;
        logic [2:0] tgt;
        logic [2:0] ctl2;
        logic       ok;
        ctl  = g[5:3];
        tgt  = g[2:0];
        ctl2 = (ctl == 3'd4) ? 3'd0 : ctl + 3'd1;
        ok   = 1'b0;
        case (g[7:6])
            2'b00:   ok = (tgt <= 3'd4);
            2'b01:   ok = (ctl <= 3'd4) && (tgt <= 3'd4) && (ctl != tgt);
            2'b10:   ok = 1'b1;
            default: ok = (ctl <= 3'd4) && (tgt <= 3'd4) && (tgt != ctl) && (tgt != ctl2);
        endcase
        return ok;
    endfunction

    // Every gate is self-inverse, so the same function serves forward and undo.
    function automatic logic [4:0] apply_gate(input logic [4:0] s, input logic [7:0] g);
        logic [2:0] ctl;
        logic [2:0] ctl2;
        logic [4:0] flip;
        logic [4:0] sh1;
        logic [4:0] sh2;
        logic [4:0] r;
        ctl  = g[5:3];
        ctl2 = (ctl == 3'd4) ? 3'd0 : ctl + 3'd1;
        flip = 5'b00001 << g[2:0];
        sh1  = s >> ctl;
        sh2  = s >> ctl2;
        r    = s;
        case (g[7:6])
            2'b00:   r = s ^ flip;
            2'b01:   r = sh1[0] ? (s ^ flip) : s;
            2'b10:   r = s ^ {{4{s[0]}}, 1'b0};
            default: r = (sh1[0] && sh2[0]) ? (s ^ flip) : s;
        endcase
        return r;
    endfunction

    logic [4:0] state_q;
    logic       done_q;
    logic       err_q;

    assign state_out = state_q;
    assign gate_done = done_q;
    assign err       = err_q;

`ifdef REV_GATE_HIST_EN
    localparam int IW = $clog2(HIST_DEPTH);

    logic [7:0]    hist_mem [HIST_DEPTH];
    logic [4:0]    cnt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic          push;

    assign wr_idx     = cnt[IW-1:0];
    assign top_idx    = IW'(cnt - 5'd1);
    assign hist_count = cnt;
    assign cmd_ready  = !rst && !load_valid && !undo_req && (cnt < 5'(HIST_DEPTH));
    assign push       = cmd_valid && cmd_ready && gate_legal(cmd);

    always_ff @(posedge clk) begin
        if (push) begin
            hist_mem[wr_idx] <= cmd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (load_valid) begin
                state_q <= load_data;
                cnt     <= '0;
            end else if (undo_req) begin
                if (cnt != 5'd0) begin
                    state_q <= apply_gate(state_q, hist_mem[top_idx]);
                    cnt     <= cnt - 5'd1;
                    done_q  <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (cmd_valid && cmd_ready) begin
                if (push) begin
                    state_q <= apply_gate(state_q, cmd);
                    cnt     <= cnt + 5'd1;
                    done_q  <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`else
    assign hist_count = '0;
    assign cmd_ready  = !rst && !load_valid;

    // An undo in the same cycle still outranks the command, which is consumed and dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (load_valid) begin
                state_q <= load_data;
            end else if (undo_req) begin
                err_q <= 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                if (gate_legal(cmd)) begin
                    state_q <= apply_gate(state_q, cmd);
                    done_q  <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rev_gate_sequencer.sv
// Randomized bench for rev_gate_sequencer against a queue-based reference model.
module tb_rev_gate_sequencer;

    localparam int HD = 8;
`ifdef REV_GATE_HIST_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [4:0] load_data;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic       cmd_ready;
    logic       undo_req;
    logic [4:0] state_out;
    logic [4:0] hist_count;
    logic       gate_done;
    logic       err;

    rev_gate_sequencer #(.HIST_DEPTH(HD)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .undo_req   (undo_req),
        .state_out  (state_out),
        .hist_count (hist_count),
        .gate_done  (gate_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model
    logic [4:0] m_state;
    logic [7:0] hist_q[$];
    bit         m_done;
    bit         m_err;

    function automatic logic [7:0] mk(input int op, input int ctl, input int tgt);
        logic [7:0] c;
        c[7:6] = op[1:0];
        c[5:3] = ctl[2:0];
        c[2:0] = tgt[2:0];
        return c;
    endfunction

    function automatic bit ref_legal(input logic [7:0] c);
        int op, a, t;
        op = int'(c[7:6]);
        a  = int'(c[5:3]);
        t  = int'(c[2:0]);
        case (op)
            0: return t < 5;
            1: return a < 5 && t < 5 && a != t;
            2: return 1'b1;
            default: return a < 5 && t < 5 && t != a && t != (a + 1) % 5;
        endcase
    endfunction

    function automatic logic [4:0] ref_gate(input logic [4:0] s, input logic [7:0] c);
        bit b[5];
        int op, a, t;
        logic [4:0] r;
        op = int'(c[7:6]);
        a  = int'(c[5:3]);
        t  = int'(c[2:0]);
        for (int k = 0; k < 5; k++) b[k] = s[k];
        case (op)
            0: b[t] = !b[t];
            1: if (b[a]) b[t] = !b[t];
            2: for (int k = 1; k < 5; k++) b[k] = b[k] ^ b[0];
            default: if (b[a] && b[(a + 1) % 5]) b[t] = !b[t];
        endcase
        for (int k = 0; k < 5; k++) r[k] = b[k];
        return r;
    endfunction

    function automatic bit exp_ready(input bit lv, input bit ur);
        if (HIST_ON) return !lv && !ur && (hist_q.size() < HD);
        return !lv;
    endfunction

    task automatic cycle(input bit lv, input logic [4:0] ld, input bit cv,
                         input logic [7:0] c, input bit ur);
        bit er;
        logic [7:0] g;
        load_valid = lv;
        load_data  = ld;
        cmd_valid  = cv;
        cmd        = c;
        undo_req   = ur;
        #2;
        er = exp_ready(lv, ur);
        chk("cmd_ready", cmd_ready, er);
        m_done = 0;
        m_err  = 0;
        if (lv) begin
            m_state = ld;
            hist_q.delete();
        end else if (ur) begin
            if (HIST_ON && hist_q.size() > 0) begin
                g = hist_q.pop_back();
                m_state = ref_gate(m_state, g);
                m_done = 1;
            end else begin
                m_err = 1;
            end
        end else if (cv && er) begin
            if (ref_legal(c)) begin
                m_state = ref_gate(m_state, c);
                if (HIST_ON) hist_q.push_back(c);
                m_done = 1;
            end else begin
                m_err = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("state_out", state_out, m_state);
        chk("hist_count", hist_count, hist_q.size());
        chk("gate_done", gate_done, m_done);
        chk("err", err, m_err);
        chk("done_err_excl", gate_done & err, 1'b0);
    endtask

    task automatic mid_reset();
        load_valid = 1'b0;
        undo_req   = 1'b0;
        cmd_valid  = 1'b1;
        cmd        = mk(0, 0, 1);
        rst = 1'b1;
        #1;
        chk("rst_state", state_out, 5'd0);
        chk("rst_hist", hist_count, 5'd0);
        chk("rst_done", gate_done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = '0;
        hist_q.delete();
    endtask

    initial begin
        logic [7:0] rc;
        rst = 1'b1;
        load_valid = 0; load_data = 0; cmd_valid = 0; cmd = 0; undo_req = 0;
        m_state = '0;
        #1;
        chk("init_state", state_out, 5'd0);
        chk("init_hist", hist_count, 5'd0);
        chk("init_ready", cmd_ready, 1'b0);
        chk("init_flags", {gate_done, err}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load then FANOUT
        cycle(1, 5'b00001, 0, 8'h00, 0);
        cycle(0, 5'd0, 1, mk(2, 0, 0), 0);
        chk("fanout_state", state_out, 5'b11111);
        chk("fanout_done", gate_done, 1'b1);

        // CNOT, TOFFOLI, two undos
        cycle(1, 5'b00011, 0, 8'h00, 0);
        cycle(0, 5'd0, 1, mk(1, 1, 4), 0);
        chk("cnot_state", state_out, 5'b10011);
        cycle(0, 5'd0, 1, mk(3, 0, 2), 0);
        chk("toff_state", state_out, 5'b10111);
        cycle(0, 5'd0, 0, 8'h00, 1);
        chk("undo1_state", state_out, HIST_ON ? 5'b10011 : 5'b10111);
        cycle(0, 5'd0, 0, 8'h00, 1);
        chk("undo2_state", state_out, HIST_ON ? 5'b00011 : 5'b10111);

        // Fill history with NOTs, ninth held until an undo
        cycle(1, 5'd0, 0, 8'h00, 0);
        for (int i = 0; i < HD; i++) cycle(0, 5'd0, 1, mk(0, 0, 0), 0);
        chk("full_hist", hist_count, HIST_ON ? 5'(HD) : 5'd0);
        cycle(0, 5'd0, 1, mk(0, 0, 0), 0);
        cycle(0, 5'd0, 1, mk(0, 0, 0), 1);
        cycle(0, 5'd0, 1, mk(0, 0, 0), 0);

        // Illegal commands and empty undo
        cycle(1, 5'b01010, 0, 8'h00, 0);
        cycle(0, 5'd0, 1, mk(1, 2, 2), 0);
        chk("ill_cnot_err", err, 1'b1);
        cycle(0, 5'd0, 1, mk(0, 0, 6), 0);
        chk("ill_not_err", err, 1'b1);
        cycle(0, 5'd0, 1, mk(3, 4, 0), 0);
        cycle(0, 5'd0, 1, mk(3, 7, 1), 0);
        cycle(0, 5'd0, 0, 8'h00, 1);
        chk("empty_undo_err", err, 1'b1);
        chk("empty_undo_state", state_out, 5'b01010);

        // All three in one cycle, then async reset mid-stream
        cycle(0, 5'd0, 1, mk(0, 0, 3), 0);
        cycle(1, 5'b00110, 1, mk(0, 0, 1), 1);
        chk("prio_state", state_out, 5'b00110);
        cycle(0, 5'd0, 1, mk(2, 0, 0), 0);
        mid_reset();
        cycle(0, 5'd0, 1, mk(0, 0, 4), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rc = 8'($urandom);
            else rc = mk($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5));
            cycle($urandom_range(0, 31) == 0, 5'($urandom), $urandom_range(0, 3) != 0,
                  rc, $urandom_range(0, 7) == 0);
            if (i % 200 == 199) mid_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
